// File: rtl/addsub_unit.sv
// Two-stage pipelined add/subtract unit.
// Stage 1 holds the per-unit results; stage 2 registers the selected result.
module addsub_unit #(
   parameter int LENGTH = 16
) (
   input  logic              sig_clock,
   input  logic              sig_rst,
   input  logic [1:0]        operation,
   input  logic [LENGTH-1:0] sig_ina,
   input  logic [LENGTH-1:0] sig_inb,
   output logic [LENGTH:0]   sig_out,
   output logic              sig_valid
);

   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_ADD = 2'b10;

   logic              add_en;
   logic              sub_en;
   logic [LENGTH:0]   add_q;
   logic [LENGTH:0]   sub_q;
   logic [1:0]        op_q;
   logic [LENGTH:0]   ext_a;
   logic [LENGTH:0]   ext_b;

   assign add_en = operation[1] & ~operation[0];
   assign sub_en = operation[0] & ~operation[1];
   assign ext_a  = {1'b0, sig_ina};
   assign ext_b  = {1'b0, sig_inb};

   // Idle unit keeps its last result; op_q picks the matching one later.
   always_ff @(posedge sig_clock or negedge sig_rst) begin
      if (!sig_rst) begin
         add_q <= '0;
         sub_q <= '0;
         op_q  <= 2'b00;
      end else begin
         if (add_en) add_q <= ext_a + ext_b;
         if (sub_en) sub_q <= ext_a - ext_b;
         op_q <= operation;
      end
   end

   always_ff @(posedge sig_clock or negedge sig_rst) begin
      if (!sig_rst) begin
         sig_out   <= '0;
         sig_valid <= 1'b0;
      end else begin
         unique case (op_q)
            OP_SUB: begin
               sig_out   <= sub_q;
               sig_valid <= 1'b1;
            end
            OP_ADD: begin
               sig_out   <= add_q;
               sig_valid <= 1'b1;
            end
            default: begin
               sig_out   <= '0;
               sig_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_addsub_unit.sv
// Randomized and directed bench for addsub_unit.
// Reference results come from plain integer arithmetic.
module tb_addsub_unit;

   localparam int LENGTH = 16;
   localparam int MODV   = 1 << (LENGTH + 1);

   logic              sig_clock;
   logic              sig_rst;
   logic [1:0]        operation;
   logic [LENGTH-1:0] sig_ina;
   logic [LENGTH-1:0] sig_inb;
   logic [LENGTH:0]   sig_out;
   logic              sig_valid;

   int checks;
   int failures;

   addsub_unit #(.LENGTH(LENGTH)) dut (
      .sig_clock (sig_clock),
      .sig_rst   (sig_rst),
      .operation (operation),
      .sig_ina   (sig_ina),
      .sig_inb   (sig_inb),
      .sig_out   (sig_out),
      .sig_valid (sig_valid)
   );

   initial sig_clock = 1'b0;
   always #5 sig_clock = ~sig_clock;

   // Expected {valid, result} for one issued op.
   function automatic logic [LENGTH+1:0] model(input logic [1:0] op,
                                               input int a, input int b);
      int r;
      if (op == 2'b10) begin
         r = a + b;
         return {1'b1, r[LENGTH:0]};
      end
      if (op == 2'b01) begin
         r = (a - b + MODV) % MODV;
         return {1'b1, r[LENGTH:0]};
      end
      return '0;
   endfunction

   task automatic drive(input logic [1:0] op, input int a, input int b);
      @(negedge sig_clock);
      operation = op;
      sig_ina   = a[LENGTH-1:0];
      sig_inb   = b[LENGTH-1:0];
      @(posedge sig_clock);
      #1;
   endtask

   task automatic test_reset;
      sig_rst = 1'b1;
      operation = 2'b00;
      sig_ina = '0;
      sig_inb = '0;
      #2 sig_rst = 1'b0;
      #1;
      checks++;
      if (sig_out !== '0) begin
         failures++;
         $display("FAIL reset_out got=%h want=0", sig_out);
      end
      checks++;
      if (sig_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_valid got=%b want=0", sig_valid);
      end
      @(negedge sig_clock);
      sig_rst = 1'b1;
   endtask

   task automatic test_reset_midstream;
      drive(2'b10, 3, 4);
      operation = 2'b00;
      #2 sig_rst = 1'b0;
      #1;
      checks++;
      if (sig_out !== '0 || sig_valid !== 1'b0) begin
         failures++;
         $display("FAIL midreset_async got=%h/%b want=0/0", sig_out, sig_valid);
      end
      @(negedge sig_clock);
      sig_rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         drive(2'b00, 0, 0);
         checks++;
         if (sig_out !== '0 || sig_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_stale[%0d] got=%h/%b want=0/0",
                     i, sig_out, sig_valid);
         end
      end
   endtask

   task automatic test_directed;
      logic [1:0] ops [12] = '{2'b10, 2'b01, 2'b01, 2'b10, 2'b01,
                               2'b00, 2'b11, 2'b10, 2'b01, 2'b10,
                               2'b01, 2'b01};
      int as [12] = '{'hFFFF, 5, 7, 10, 50, 0, 1, 1, 0, 'hFFFF, 'h1234, 0};
      int bs [12] = '{1, 7, 5, 20, 8, 0, 1, 1, 1, 'hFFFF, 'h1234, 0};
      logic [LENGTH+1:0] exp;
      logic [LENGTH+1:0] hard [12] = '{18'h3_0000, 18'h3_FFFE, 18'h2_0002,
                                       18'h2_001E, 18'h2_002A, 18'h0_0000,
                                       18'h0_0000, 18'h2_0002, 18'h3_FFFF,
                                       18'h3_FFFE, 18'h2_0000, 18'h2_0000};
      for (int i = 0; i <= 12; i++) begin
         if (i < 12) drive(ops[i], as[i], bs[i]);
         else drive(2'b00, 0, 0);
         if (i > 0) begin
            exp = model(ops[i-1], as[i-1], bs[i-1]);
            checks++;
            if ({sig_valid, sig_out} !== exp || exp !== hard[i-1]) begin
               failures++;
               $display("FAIL directed[%0d] got=%b/%h want=%h",
                        i - 1, sig_valid, sig_out, hard[i-1]);
            end
         end
      end
   endtask

   task automatic test_idle_hold;
      logic [1:0] ops [5] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b01};
      int as [5];
      int bs [5];
      logic [LENGTH+1:0] exp;
      for (int i = 0; i < 5; i++) begin
         as[i] = (ops[i] == 2'b01) ? 9 : int'($urandom_range(0, 'hFFFF));
         bs[i] = (ops[i] == 2'b01) ? 4 : int'($urandom_range(0, 'hFFFF));
      end
      for (int i = 0; i <= 5; i++) begin
         if (i < 5) drive(ops[i], as[i], bs[i]);
         else drive(2'b00, 0, 0);
         if (i > 0) begin
            exp = model(ops[i-1], as[i-1], bs[i-1]);
            checks++;
            if ({sig_valid, sig_out} !== exp) begin
               failures++;
               $display("FAIL idle_hold[%0d] got=%b/%h want=%h",
                        i - 1, sig_valid, sig_out, exp);
            end
         end
      end
   endtask

   task automatic test_random;
      logic [LENGTH+1:0] expq [$];
      logic [LENGTH+1:0] exp;
      logic [1:0] op;
      int a;
      int b;
      for (int i = 0; i <= 300; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = int'($urandom_range(0, 'hFFFF));
         b  = int'($urandom_range(0, 'hFFFF));
         if (i % 17 == 0) b = a;
         if (i == 300) op = 2'b00;
         drive(op, a, b);
         if (expq.size() > 0) begin
            exp = expq.pop_front();
            checks++;
            if ({sig_valid, sig_out} !== exp) begin
               failures++;
               $display("FAIL random[%0d] got=%b/%h want=%h",
                        i - 1, sig_valid, sig_out, exp);
            end
         end
         expq.push_back(model(op, a, b));
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_reset_midstream();
      test_directed();
      test_idle_hold();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/addsub_unit.md
Name: addsub_unit

Overview:
- Two-stage pipelined arithmetic unit: one registered adder stage, one registered subtractor stage, and a registered output select, driven from a 2-bit operation code.
- Sits behind the simpleadder_if-style interface as the datapath core.
- Result is LENGTH+1 bits wide, with the carry or borrow in the MSB.

Parameters:
- LENGTH, 16, operand width in bits; result width is LENGTH+1.

Ports:
- sig_clock  input  1  single clock; all state updates on its rising edge.
- sig_rst  input  1  asynchronous, active-low reset.
- operation  input  2  op select: 2'b01 = subtract, 2'b10 = add, 2'b00/2'b11 = no operation.
- sig_ina  input  LENGTH  operand A, unsigned.
- sig_inb  input  LENGTH  operand B, unsigned.
- sig_out  output  LENGTH+1  registered result.
- sig_valid  output  1  high for one cycle when sig_out holds a result from a valid op.

Behaviour:
- Reset (sig_rst=0, asynchronous, no clock needed):
  - sig_out = 0, sig_valid = 0.
  - Internal adder and subtractor result registers = 0.
  - Pipelined op register = 2'b00.
  - Reset dominates any in-flight operation; results issued before reset release are discarded.
- Enables: add_en = operation[1] & ~operation[0]; sub_en = operation[0] & ~operation[1].
- Stage 1, adder (each rising edge):
  - If add_en: add_q <= {1'b0,A} + {1'b0,B}, MSB = carry out.
  - Else add_q holds.
- Stage 1, subtractor (each rising edge):
  - If sub_en: sub_q <= {1'b0,A} - {1'b0,B}, modulo 2^(LENGTH+1).
  - MSB = 1 when A < B (borrow); low LENGTH bits are the two's-complement difference.
  - Else sub_q holds.
- Stage 1, op register: op_q <= operation every edge.
- Stage 2, output register (each rising edge, selected by op_q, not the live operation):
  - op_q = 01: sig_out <= sub_q, sig_valid <= 1.
  - op_q = 10: sig_out <= add_q, sig_valid <= 1.
  - Otherwise: sig_out <= 0, sig_valid <= 0. No X is ever driven.
- Latency: operands and op sampled on edge N; sig_out/sig_valid update on edge N+1 and are visible after it.
- Throughput: one op per cycle; back-to-back ops of any mix are independent and complete in issue order.
- Only the selected unit updates; the idle unit keeps its last result. This must not affect sig_out, which always reflects the op issued with the matching data.
- Boundary cases:
  - All-ones + all-ones gives MSB carry = 1.
  - 0 - 1 gives all ones across LENGTH+1 bits.
  - A == B subtract gives 0 with sig_valid = 1.
  - op=2'b11 is treated as no-op; neither unit updates.

Test Plan:
- Reset mid-stream: issue add 3+4, assert sig_rst=0 between clock edges -> sig_out=0 and sig_valid=0 immediately; after release, no stale result appears.
- Add with carry: A=16'hFFFF, B=16'h0001, operation=10 -> one cycle later sig_out=17'h10000, sig_valid=1.
- Subtract with borrow: A=5, B=7, operation=01 -> sig_out=17'h1FFFE, sig_valid=1. Then A=7, B=5 -> sig_out=17'h00002.
- Back-to-back mix: add 10+20, then sub 50-8, then no-op (00) on consecutive cycles -> sig_out sequence 30, 42, 0 with sig_valid 1, 1, 0.
- Invalid op 11 with A=1, B=1 -> sig_out=0, sig_valid=0. A following add 1+1 -> 2, confirming neither unit was disturbed.
- Idle-hold check: sub 9-4 (=5), then three cycles of add; then sub again with A=9, B=4 -> every sub result reads 5 and every add result matches its own operands.
